// File: rtl/vector_fb_pkg.sv
// Shared definitions for the framebuffer SRAM arbiter.
//   VRAM_BASE    : default framebuffer base address (plane 0)
//   PLANE_STRIDE : address distance between consecutive bit planes
//   arb_state_e  : arbiter FSM state encoding
//   vram_addr()  : forms the SRAM address of one plane byte
package vector_fb_pkg;

  localparam logic [15:0] VRAM_BASE    = 16'h8000;
  localparam logic [15:0] PLANE_STRIDE = 16'h2000;

  typedef enum logic [3:0] {
    IDLE,
    VID0,
    VID1,
    VID2,
    VID3,
    RD1,
    RD2,
    WR1,
    WR2
  } arb_state_e;

  // Each plane is a 32x256 byte array: the column selects a 256-byte page
  // and the framebuffer row selects the byte within that page.
  function automatic logic [15:0] vram_addr(input logic [15:0] base,
                                            input logic [1:0]  plane,
                                            input logic [4:0]  col,
                                            input logic [7:0]  row);
    return base + (16'(plane) * PLANE_STRIDE) + {3'b000, col, 8'h00} + {8'h00, row};
  endfunction

endpackage

// File: rtl/fb_sram_arbiter.sv
// Arbitrates one asynchronous SRAM between the video fetcher and the CPU.
// A video request fetches one byte from each of the four planes in
// consecutive cycles; a CPU access takes two cycles and is acknowledged by
// a one-cycle pulse.  Video wins whenever both sides compete in IDLE.
//
// Ports:
//   clk24, rst_n                  : 24 MHz clock, synchronous active-low reset
//   retrace                       : high outside visible lines; video requests ignored
//   fb_row[8:0]                   : scan-doubled row, byte row is fb_row[8:1]
//   vid_req, vid_col[4:0]         : one-cycle fetch request with its column
//   vid_data[31:0], vid_valid     : {p3,p2,p1,p0} and its one-cycle valid pulse
//   vid_overrun                   : sticky, a request arrived while one was pending
//   cpu_req/we/addr/wdata         : CPU level request
//   cpu_rdata, cpu_ack            : read data and one-cycle acknowledge
//   sram_addr/dout/din/we_n/oe_n  : SRAM pins, outputs registered (glitch-free)
module fb_sram_arbiter #(
  parameter logic [15:0] VRAM_BASE = vector_fb_pkg::VRAM_BASE
) (
  input  logic        clk24,
  input  logic        rst_n,
  input  logic        retrace,
  input  logic [8:0]  fb_row,
  input  logic        vid_req,
  input  logic [4:0]  vid_col,
  output logic [31:0] vid_data,
  output logic        vid_valid,
  output logic        vid_overrun,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic [15:0] sram_addr,
  output logic [7:0]  sram_dout,
  input  logic [7:0]  sram_din,
  output logic        sram_we_n,
  output logic        sram_oe_n
);
  import vector_fb_pkg::*;

  arb_state_e  state_q;
  arb_state_e  state_d;
  logic        vid_pending;
  logic [4:0]  col_q;
  logic [7:0]  row_q;
  logic        vid_take;
  logic        vid_clash;
  logic [4:0]  col_next;
  logic [7:0]  row_next;
  logic [15:0] addr_d;
  logic [7:0]  dout_d;
  logic        we_n_d;
  logic        oe_n_d;
  logic        row_lsb_unused;

  // The low row bit only distinguishes the two scan-doubled copies of a line.
  assign row_lsb_unused = fb_row[0];

  // A new request is accepted only when none is queued; otherwise it is an overrun.
  assign vid_take  = vid_req & ~retrace & ~vid_pending;
  assign vid_clash = vid_req & ~retrace &  vid_pending;

  // The address for VID0 is formed in the same cycle the request is taken,
  // so look through the column/row latches.
  assign col_next = vid_take ? vid_col     : col_q;
  assign row_next = vid_take ? fb_row[8:1] : row_q;

  always_ff @(posedge clk24) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The cycle in which cpu_ack is high is spent idle as bus turnaround,
  // so neither side starts an access in it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_ack)                      state_d = IDLE;
        else if (vid_pending || vid_take) state_d = VID0;
        else if (cpu_req)                 state_d = cpu_we ? WR1 : RD1;
      end
      VID0:    state_d = VID1;
      VID1:    state_d = VID2;
      VID2:    state_d = VID3;
      VID3:    state_d = IDLE;
      RD1:     state_d = RD2;
      RD2:     state_d = IDLE;
      WR1:     state_d = WR2;
      WR2:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM pin values are decoded from the next state and registered, so the
  // pins change cleanly on the clock edge that enters each state.
  always_comb begin
    addr_d = 16'h0000;
    dout_d = 8'h00;
    we_n_d = 1'b1;
    oe_n_d = 1'b1;
    case (state_d)
      VID0: begin addr_d = vram_addr(VRAM_BASE, 2'd0, col_next, row_next); oe_n_d = 1'b0; end
      VID1: begin addr_d = vram_addr(VRAM_BASE, 2'd1, col_next, row_next); oe_n_d = 1'b0; end
      VID2: begin addr_d = vram_addr(VRAM_BASE, 2'd2, col_next, row_next); oe_n_d = 1'b0; end
      VID3: begin addr_d = vram_addr(VRAM_BASE, 2'd3, col_next, row_next); oe_n_d = 1'b0; end
      RD1, RD2: begin addr_d = cpu_addr; oe_n_d = 1'b0; end
      WR1: begin addr_d = cpu_addr; dout_d = cpu_wdata; end
      WR2: begin addr_d = cpu_addr; dout_d = cpu_wdata; we_n_d = 1'b0; end
      default: ;
    endcase
  end

  // Datapath: pin registers, request latches, capture registers and status pulses.
  always_ff @(posedge clk24) begin
    if (!rst_n) begin
      sram_addr   <= 16'h0000;
      sram_dout   <= 8'h00;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      vid_pending <= 1'b0;
      vid_overrun <= 1'b0;
      vid_valid   <= 1'b0;
      vid_data    <= 32'h0000_0000;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= 8'h00;
      col_q       <= 5'd0;
      row_q       <= 8'h00;
    end else begin
      sram_addr <= addr_d;
      sram_dout <= dout_d;
      sram_we_n <= we_n_d;
      sram_oe_n <= oe_n_d;
      if (vid_take) begin
        vid_pending <= 1'b1;
        col_q       <= vid_col;
        row_q       <= fb_row[8:1];
      end else if (state_q == VID3) begin
        vid_pending <= 1'b0;
      end
      if (vid_clash) vid_overrun <= 1'b1;
      vid_valid <= (state_q == VID3);
      cpu_ack   <= (state_q == RD2) || (state_q == WR2);
      case (state_q)
        VID0:    vid_data[7:0]   <= sram_din;
        VID1:    vid_data[15:8]  <= sram_din;
        VID2:    vid_data[23:16] <= sram_din;
        VID3:    vid_data[31:24] <= sram_din;
        RD2:     cpu_rdata       <= sram_din;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Directed bench for fb_sram_arbiter with an SRAM model and scoreboards for
// video words and CPU read data.  Inputs are driven and outputs sampled on
// the falling clock edge; one call of step() advances one clock cycle.
module tb_fb_sram_arbiter;

  typedef struct {
    bit         is_read;
    logic [7:0] data;
  } cpu_exp_t;

  logic        clk24;
  logic        rst_n;
  logic        retrace;
  logic [8:0]  fb_row;
  logic        vid_req;
  logic [4:0]  vid_col;
  logic [31:0] vid_data;
  logic        vid_valid;
  logic        vid_overrun;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [15:0] sram_addr;
  logic [7:0]  sram_dout;
  logic [7:0]  sram_din;
  logic        sram_we_n;
  logic        sram_oe_n;

  bit [7:0] mem [0:65535];
  bit       written [0:65535];

  logic [31:0] vid_exp_q [$];
  cpu_exp_t    cpu_exp_q [$];

  int n_compared;
  int n_mismatched;
  int cyc;
  int valid_cnt;
  int last_valid_cyc;
  int ack_cnt;
  int last_ack_cyc;
  int we_low_cnt;
  int last_we_low_cyc;
  int sram_active_cnt;
  int req_cyc;
  int w0;
  int a0;
  int k0;
  int vc0;

  fb_sram_arbiter #(.VRAM_BASE(16'h8000)) dut (
    .clk24       (clk24),
    .rst_n       (rst_n),
    .retrace     (retrace),
    .fb_row      (fb_row),
    .vid_req     (vid_req),
    .vid_col     (vid_col),
    .vid_data    (vid_data),
    .vid_valid   (vid_valid),
    .vid_overrun (vid_overrun),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .sram_addr   (sram_addr),
    .sram_dout   (sram_dout),
    .sram_din    (sram_din),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n)
  );

  initial clk24 = 1'b0;
  always #10 clk24 = ~clk24;

  // Unwritten locations read back a fixed address-derived pattern.
  function automatic logic [7:0] pattern(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [15:0] vaddr(input logic [1:0] plane, input logic [4:0] col,
                                        input logic [7:0] row);
    return 16'h8000 + 16'(plane) * 16'h2000 + 16'(col) * 16'd256 + 16'(row);
  endfunction

  function automatic logic [31:0] vid_word(input logic [4:0] col, input logic [7:0] row);
    return {pattern(vaddr(2'd3, col, row)), pattern(vaddr(2'd2, col, row)),
            pattern(vaddr(2'd1, col, row)), pattern(vaddr(2'd0, col, row))};
  endfunction

  // Asynchronous SRAM model: write strobe taken at the clock edge, read is combinational.
  always @(posedge clk24) begin
    if (!sram_we_n) begin
      mem[sram_addr]     <= sram_dout;
      written[sram_addr] <= 1'b1;
    end
  end

  always_comb begin
    sram_din = 8'hEE;
    if (!sram_oe_n) sram_din = written[sram_addr] ? mem[sram_addr] : pattern(sram_addr);
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: sample at the falling edge, check the strobe invariant,
  // pop scoreboards on valid/ack, and let the CPU requester drop cpu_req on ack.
  task automatic step();
    cpu_exp_t e;
    @(negedge clk24);
    cyc++;
    check_output("we_oe_exclusive", {31'b0, ~(~sram_we_n & ~sram_oe_n)}, 32'd1);
    if (!sram_we_n) begin
      we_low_cnt++;
      last_we_low_cyc = cyc;
    end
    if (!sram_we_n || !sram_oe_n) sram_active_cnt++;
    if (vid_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      if (vid_exp_q.size() == 0) check_output("vid_valid_unexpected", {31'b0, vid_valid}, 32'd0);
      else                       check_output("vid_data", vid_data, vid_exp_q.pop_front());
    end
    if (cpu_ack) begin
      ack_cnt++;
      last_ack_cyc = cyc;
      cpu_req = 1'b0;
      if (cpu_exp_q.size() == 0) check_output("cpu_ack_unexpected", {31'b0, cpu_ack}, 32'd0);
      else begin
        e = cpu_exp_q.pop_front();
        if (e.is_read) check_output("cpu_rdata", {24'b0, cpu_rdata}, {24'b0, e.data});
      end
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                                input logic [7:0] rd_exp);
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_req   = 1'b1;
    cpu_exp_q.push_back('{is_read: !we, data: rd_exp});
  endtask

  task automatic wait_for_valid(input string tag, input int budget);
    int start;
    int n;
    start = valid_cnt;
    n = 0;
    while (valid_cnt == start && n < budget) begin
      step();
      n++;
    end
    check_output({tag, "_valid_seen"}, 32'(valid_cnt - start), 32'd1);
  endtask

  task automatic wait_for_ack(input string tag, input int budget);
    int start;
    int n;
    start = ack_cnt;
    n = 0;
    while (ack_cnt == start && n < budget) begin
      step();
      n++;
    end
    check_output({tag, "_ack_seen"}, 32'(ack_cnt - start), 32'd1);
  endtask

  initial begin
    logic [15:0] s1_addr [4];
    s1_addr = '{16'h8550, 16'hA550, 16'hC550, 16'hE550};
    rst_n = 1'b0; retrace = 1'b0; fb_row = 9'h000; vid_req = 1'b0; vid_col = 5'd0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    repeat (3) step();

    $display("[TB] reset state");
    check_output("rst_we_n",     {31'b0, sram_we_n},   32'd1);
    check_output("rst_oe_n",     {31'b0, sram_oe_n},   32'd1);
    check_output("rst_addr",     {16'b0, sram_addr},   32'd0);
    check_output("rst_dout",     {24'b0, sram_dout},   32'd0);
    check_output("rst_valid",    {31'b0, vid_valid},   32'd0);
    check_output("rst_overrun",  {31'b0, vid_overrun}, 32'd0);
    check_output("rst_ack",      {31'b0, cpu_ack},     32'd0);
    check_output("rst_vid_data", vid_data,             32'd0);
    check_output("rst_rdata",    {24'b0, cpu_rdata},   32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    $display("[TB] video fetch from IDLE");
    vid_col = 5'd5; fb_row = 9'h0A1; vid_req = 1'b1;
    vid_exp_q.push_back(vid_word(5'd5, 8'h50));
    req_cyc = cyc;
    for (int p = 0; p < 4; p++) begin
      step();
      vid_req = 1'b0;
      check_output($sformatf("s1_addr_p%0d", p), {16'b0, sram_addr}, {16'b0, s1_addr[p]});
      check_output($sformatf("s1_oe_n_p%0d", p), {31'b0, sram_oe_n}, 32'd0);
    end
    wait_for_valid("s1", 10);
    check_output("s1_valid_latency", 32'(last_valid_cyc - req_cyc), 32'd5);
    step();
    check_output("s1_valid_pulse", {31'b0, vid_valid}, 32'd0);

    $display("[TB] CPU write then read");
    apply_stimulus(1'b1, 16'h1234, 8'h3C, 8'h00);
    req_cyc = cyc;
    w0 = we_low_cnt;
    step();
    check_output("wr1_we_n", {31'b0, sram_we_n}, 32'd1);
    check_output("wr1_oe_n", {31'b0, sram_oe_n}, 32'd1);
    check_output("wr1_addr", {16'b0, sram_addr}, 32'h1234);
    check_output("wr1_dout", {24'b0, sram_dout}, 32'h3C);
    step();
    check_output("wr2_we_n", {31'b0, sram_we_n}, 32'd0);
    check_output("wr2_oe_n", {31'b0, sram_oe_n}, 32'd1);
    check_output("wr2_addr", {16'b0, sram_addr}, 32'h1234);
    step();
    check_output("wr_ack", {31'b0, cpu_ack}, 32'd1);
    check_output("wr_we_low_cycles", 32'(we_low_cnt - w0), 32'd1);
    check_output("wr_we_low_at_wr2", 32'(last_we_low_cyc - req_cyc), 32'd2);
    step();
    check_output("wr_ack_pulse", {31'b0, cpu_ack}, 32'd0);
    apply_stimulus(1'b0, 16'h1234, 8'h00, 8'h3C);
    req_cyc = cyc;
    wait_for_ack("rd", 10);
    check_output("rd_ack_latency", 32'(last_ack_cyc - req_cyc), 32'd3);
    check_output("rd_no_write", 32'(we_low_cnt - w0), 32'd1);
    step();

    $display("[TB] simultaneous CPU and video requests");
    apply_stimulus(1'b0, 16'h0042, 8'h00, pattern(16'h0042));
    vid_col = 5'd3; fb_row = 9'h1FE; vid_req = 1'b1;
    vid_exp_q.push_back(vid_word(5'd3, 8'hFF));
    req_cyc = cyc;
    step();
    vid_req = 1'b0;
    check_output("s3_video_first", {16'b0, sram_addr}, 32'h83FF);
    wait_for_ack("s3", 20);
    check_output("s3_ack_latency",   32'(last_ack_cyc - req_cyc),   32'd8);
    check_output("s3_valid_latency", 32'(last_valid_cyc - req_cyc), 32'd5);
    step();

    $display("[TB] video request during RD1");
    apply_stimulus(1'b0, 16'h0100, 8'h00, pattern(16'h0100));
    step();
    check_output("s4_rd1_addr", {16'b0, sram_addr}, 32'h0100);
    vid_col = 5'd31; fb_row = 9'h002; vid_req = 1'b1;
    vid_exp_q.push_back(vid_word(5'd31, 8'h01));
    req_cyc = cyc;
    step();
    vid_req = 1'b0;
    check_output("s4_rd2_not_aborted", {16'b0, sram_addr}, 32'h0100);
    wait_for_valid("s4", 20);
    check_output("s4_valid_latency", 32'(last_valid_cyc - req_cyc), 32'd8);
    check_output("s4_ack_latency",   32'(last_ack_cyc - req_cyc),   32'd2);
    step();

    $display("[TB] overrun and retrace");
    vc0 = valid_cnt;
    vid_col = 5'd1; fb_row = 9'h010; vid_req = 1'b1;
    vid_exp_q.push_back(vid_word(5'd1, 8'h08));
    req_cyc = cyc;
    step();
    vid_req = 1'b0;
    step();
    check_output("s5_overrun_clear", {31'b0, vid_overrun}, 32'd0);
    vid_col = 5'd7; fb_row = 9'h1F0; vid_req = 1'b1;
    step();
    vid_req = 1'b0;
    check_output("s5_overrun_set", {31'b0, vid_overrun}, 32'd1);
    check_output("s5_col_kept",    {16'b0, sram_addr},   32'hC108);
    wait_for_valid("s5", 10);
    check_output("s5_valid_latency", 32'(last_valid_cyc - req_cyc), 32'd5);
    repeat (6) step();
    check_output("s5_single_valid", 32'(valid_cnt - vc0), 32'd1);
    retrace = 1'b1; vid_col = 5'd2; vid_req = 1'b1;
    a0 = sram_active_cnt;
    vc0 = valid_cnt;
    step();
    vid_req = 1'b0; retrace = 1'b0;
    repeat (8) step();
    check_output("s5_retrace_no_sram", 32'(sram_active_cnt - a0), 32'd0);
    check_output("s5_retrace_no_valid", 32'(valid_cnt - vc0), 32'd0);
    check_output("s5_overrun_sticky", {31'b0, vid_overrun}, 32'd1);

    $display("[TB] reset during WR2");
    apply_stimulus(1'b1, 16'h2000, 8'hA5, 8'h00);
    step();
    step();
    check_output("s6_in_wr2", {31'b0, sram_we_n}, 32'd0);
    rst_n = 1'b0;
    cpu_req = 1'b0;
    step();
    check_output("s6_we_n",    {31'b0, sram_we_n},   32'd1);
    check_output("s6_oe_n",    {31'b0, sram_oe_n},   32'd1);
    check_output("s6_ack",     {31'b0, cpu_ack},     32'd0);
    check_output("s6_addr",    {16'b0, sram_addr},   32'd0);
    check_output("s6_overrun", {31'b0, vid_overrun}, 32'd0);
    check_output("s6_vid_data", vid_data,            32'd0);
    check_output("s6_rdata",   {24'b0, cpu_rdata},   32'd0);
    cpu_exp_q.delete();
    rst_n = 1'b1;
    a0 = sram_active_cnt;
    k0 = ack_cnt;
    repeat (6) step();
    check_output("s6_no_sram_cycles", 32'(sram_active_cnt - a0), 32'd0);
    check_output("s6_no_ack",         32'(ack_cnt - k0),         32'd0);

    check_output("vid_scoreboard_drained", 32'(vid_exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
